// File: rtl/gpio_in_pkg.sv
// Shared constants and edge-event type for the GPIO input conditioner.
package gpio_in_pkg;

  localparam int GPIO_DATA_WIDTH = 32;
  localparam int GPIO_DB_CNT_W   = 4;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_evt_t;

  function automatic edge_evt_t edge_of(input logic load, input logic val);
    edge_evt_t evt;
    evt.rise = load & val;
    evt.fall = load & ~val;
    return evt;
  endfunction

endpackage

// File: rtl/gpio_in_cond_if.sv
// Pin, configuration and status bundle between the GPIO input conditioner and its host.
interface gpio_in_cond_if
  import gpio_in_pkg::*;
#(
  parameter int DATA_WIDTH = GPIO_DATA_WIDTH,
  parameter int DB_CNT_W   = GPIO_DB_CNT_W
);

  logic [DATA_WIDTH-1:0] gpio_pin_in;
  logic [DB_CNT_W-1:0]   db_len;
  logic [DATA_WIDTH-1:0] int_rise_en;
  logic [DATA_WIDTH-1:0] int_fall_en;
  logic [DATA_WIDTH-1:0] int_mask;
  logic [DATA_WIDTH-1:0] int_clr;
  logic [DATA_WIDTH-1:0] gpio_in_sync;
  logic [DATA_WIDTH-1:0] int_status;
  logic                  irq;

  modport master (
    output gpio_pin_in, db_len, int_rise_en, int_fall_en, int_mask, int_clr,
    input  gpio_in_sync, int_status, irq
  );

  modport slave (
    input  gpio_pin_in, db_len, int_rise_en, int_fall_en, int_mask, int_clr,
    output gpio_in_sync, int_status, irq
  );

endinterface

// File: rtl/gpio_in_db_cell.sv
// One GPIO pin: 2-flop synchroniser, optional debounce (GPIO_IN_DEBOUNCE_EN) and edge detect.
module gpio_in_db_cell
  import gpio_in_pkg::*;
#(
  parameter int DB_CNT_W = GPIO_DB_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_pin,
  input  logic [DB_CNT_W-1:0] i_db_len,
  output logic                o_sync,
  output edge_evt_t           o_evt
);

  logic r_s1;
  logic r_s2;
  logic r_sync;
  logic w_load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] r_cnt;

  // >= rather than == so a shrinking db_len mid-count still releases the pin
  assign w_load = (r_s2 != r_sync) && (r_cnt >= i_db_len);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if ((r_s2 == r_sync) || w_load) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + DB_CNT_W'(1);
    end
  end
`else
  logic w_unused_db_len;

  assign w_unused_db_len = ^i_db_len;
  assign w_load          = (r_s2 != r_sync);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 1'b0;
    end else if (w_load) begin
      r_sync <= r_s2;
    end
  end

  assign o_sync = r_sync;
  assign o_evt  = edge_of(w_load, r_s2);

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: per-pin cells plus sticky edge status and combined irq.
// Debounce counters are built only when GPIO_IN_DEBOUNCE_EN is defined.
module gpio_in_cond
  import gpio_in_pkg::*;
#(
  parameter int DATA_WIDTH = GPIO_DATA_WIDTH,
  parameter int DB_CNT_W   = GPIO_DB_CNT_W
) (
  input  logic           pclk11,
  input  logic           n_p_reset11,
  gpio_in_cond_if.slave  bus
);

  logic [DATA_WIDTH-1:0] w_sync;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;
  logic [DATA_WIDTH-1:0] w_set;
  logic [DATA_WIDTH-1:0] r_status;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_pin
    edge_evt_t w_evt;

    gpio_in_db_cell #(
      .DB_CNT_W (DB_CNT_W)
    ) u_cell (
      .i_clk    (pclk11),
      .i_rst_n  (n_p_reset11),
      .i_pin    (bus.gpio_pin_in[g]),
      .i_db_len (bus.db_len),
      .o_sync   (w_sync[g]),
      .o_evt    (w_evt)
    );

    assign w_rise[g] = w_evt.rise;
    assign w_fall[g] = w_evt.fall;
  end

  assign w_set = (w_rise & bus.int_rise_en) | (w_fall & bus.int_fall_en);

  // a new event on the same edge as its clear keeps the bit set
  always_ff @(posedge pclk11 or negedge n_p_reset11) begin
    if (!n_p_reset11) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~bus.int_clr) | w_set;
    end
  end

  assign bus.gpio_in_sync = w_sync;
  assign bus.int_status   = r_status;
  assign bus.irq          = |(r_status & ~bus.int_mask);

endmodule
